// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: FSM state encodings and default widths for the hazard controller.
// HAZARD_FWD_EN (when defined) selects the forwarding datapath variant: only load-use is a raw hazard.
package pipeline_hazard_controller_pkg;
  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_DMEM_WAIT = 2'd1,
    HZ_IMEM_WAIT = 2'd2,
    HZ_HALT      = 2'd3
  } hz_state_e;
  localparam int HZ_REG_AW = 2;
  localparam int HZ_CNT_W  = 16;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: datapath <-> hazard controller signal bundle.
// master = datapath side (drives pipeline status), slave = controller side (drives register controls).
interface pipeline_hazard_controller_if
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int CNT_W  = HZ_CNT_W
);
  logic [REG_AW-1:0] rs_ID, rt_ID, dest_EX, dest_MEM;
  logic              use_rs_ID, use_rt_ID, RegWrite_EX, RegWrite_MEM, d_readM_EX;
  logic              mispredict_EX, i_mem_ready, d_mem_req, d_mem_ready, is_halted_WB;
  logic              pc_write, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted;
  logic [CNT_W-1:0]  stall_cycles;
  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, dest_EX, dest_MEM, RegWrite_EX, RegWrite_MEM, d_readM_EX,
           mispredict_EX, i_mem_ready, d_mem_req, d_mem_ready, is_halted_WB,
    input  pc_write, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted, stall_cycles
  );
  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, dest_EX, dest_MEM, RegWrite_EX, RegWrite_MEM, d_readM_EX,
           mispredict_EX, i_mem_ready, d_mem_req, d_mem_ready, is_halted_WB,
    output pc_write, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller_raw_hazard_detect.sv
// pipeline_hazard_controller_raw_hazard_detect: combinational RAW check of ID sources against EX/MEM writers.
// HAZARD_FWD_EN defined: only load-use against EX; otherwise any EX or MEM writer match (WB never hazards).
module pipeline_hazard_controller_raw_hazard_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [REG_AW-1:0] dest_ex_i,
  input  logic [REG_AW-1:0] dest_mem_i,
  input  logic              wr_ex_i,
  input  logic              wr_mem_i,
  input  logic              load_ex_i,
  output logic              hazard_o
);
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit  = wr_ex_i & ((use_rs_i & (rs_i == dest_ex_i)) | (use_rt_i & (rt_i == dest_ex_i)));
    mem_hit = wr_mem_i & ((use_rs_i & (rs_i == dest_mem_i)) | (use_rt_i & (rt_i == dest_mem_i)));
  end
`ifdef HAZARD_FWD_EN
  logic unused_mem;
  assign unused_mem = mem_hit;
  assign hazard_o = load_ex_i & ex_hit;
`else
  logic unused_fwd;
  assign unused_fwd = load_ex_i;
  assign hazard_o = ex_hit | mem_hit;
`endif
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/PC-enable generator with a RUN/DMEM_WAIT/IMEM_WAIT/HALT FSM.
// Build option HAZARD_FWD_EN narrows raw hazards to load-use (see raw_hazard_detect).
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W  = HZ_CNT_W,
  parameter int REG_AW = HZ_REG_AW
) (
  input logic clk,
  input logic reset_n,
  pipeline_hazard_controller_if.slave hz
);
  hz_state_e        state_q, state_d;
  logic             pend_q, pend_d, halted_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw, dmem, pc_wr, st_all, st_ifid, fl_ifid, fl_idex;

  pipeline_hazard_controller_raw_hazard_detect #(.REG_AW(REG_AW)) u_raw_hazard_detect (
    .rs_i      (hz.rs_ID),
    .rt_i      (hz.rt_ID),
    .use_rs_i  (hz.use_rs_ID),
    .use_rt_i  (hz.use_rt_ID),
    .dest_ex_i (hz.dest_EX),
    .dest_mem_i(hz.dest_MEM),
    .wr_ex_i   (hz.RegWrite_EX),
    .wr_mem_i  (hz.RegWrite_MEM),
    .load_ex_i (hz.d_readM_EX),
    .hazard_o  (raw)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_wr   = 1'b1;
    st_all  = 1'b0;
    st_ifid = 1'b0;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    dmem    = hz.d_mem_req & ~hz.d_mem_ready;
    if (!reset_n) begin
      pc_wr   = 1'b0;
      fl_ifid = 1'b1;
      fl_idex = 1'b1;
    end else if (state_q == HZ_HALT || hz.is_halted_WB) begin
      state_d = HZ_HALT;
      pc_wr   = 1'b0;
      st_all  = 1'b1;
    end else if (state_q == HZ_IMEM_WAIT) begin
      if (dmem) begin
        pc_wr  = 1'b0;
        st_all = 1'b1;
      end else if (hz.mispredict_EX) begin
        // Redirect while fetch is still busy: remember that the word in flight is wrong-path.
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
        pc_wr   = hz.i_mem_ready;
        pend_d  = ~hz.i_mem_ready;
        state_d = hz.i_mem_ready ? HZ_RUN : HZ_IMEM_WAIT;
      end else if (!hz.i_mem_ready) begin
        pc_wr   = 1'b0;
        fl_ifid = 1'b1;
      end else begin
        state_d = HZ_RUN;
        pend_d  = 1'b0;
        if (pend_q) begin
          fl_ifid = 1'b1;
        end else if (raw) begin
          pc_wr   = 1'b0;
          st_ifid = 1'b1;
          fl_idex = 1'b1;
        end
      end
    end else if (state_q == HZ_DMEM_WAIT && !hz.d_mem_ready) begin
      pc_wr  = 1'b0;
      st_all = 1'b1;
    end else begin
      state_d = HZ_RUN;
      if (dmem) begin
        state_d = HZ_DMEM_WAIT;
        pc_wr   = 1'b0;
        st_all  = 1'b1;
      end else if (hz.mispredict_EX) begin
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end else if (!hz.i_mem_ready) begin
        state_d = HZ_IMEM_WAIT;
        pc_wr   = 1'b0;
        fl_ifid = 1'b1;
      end else if (raw) begin
        pc_wr   = 1'b0;
        st_ifid = 1'b1;
        fl_idex = 1'b1;
      end
    end
    cnt_d = (!pc_wr && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= HZ_RUN;
      pend_q   <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      halted_q <= halted_q | (state_d == HZ_HALT);
      cnt_q    <= cnt_d;
    end
  end

  assign hz.pc_write     = pc_wr;
  assign hz.stall_IF_ID  = st_all | st_ifid;
  assign hz.stall_ID_EX  = st_all;
  assign hz.stall_EX_MEM = st_all;
  assign hz.flush_IF_ID  = fl_ifid;
  assign hz.flush_ID_EX  = fl_idex;
  assign hz.halted       = halted_q;
  assign hz.stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench; expected controls queued per driven cycle, checked at negedge.
// A narrow stall counter is used so saturation is reachable quickly.
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 4;
  localparam logic [5:0] NORM = 6'b100000;
  localparam logic [5:0] HAZ  = 6'b010001;
  localparam logic [5:0] ALL  = 6'b011100;
  localparam logic [5:0] MISP = 6'b100011;
  localparam logic [5:0] IMW  = 6'b000010;
  localparam logic [5:0] RSTV = 6'b000011;
`ifdef HAZARD_FWD_EN
  localparam logic [5:0] ALU_HAZ = NORM;
`else
  localparam logic [5:0] ALU_HAZ = HAZ;
`endif

  typedef struct packed {
    logic [5:0]       ctl;
    logic             halted;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  string tq[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic exp_halted = 1'b0;
  exp_t e;
  string t;

  pipeline_hazard_controller_if #(.REG_AW(2), .CNT_W(CNT_W)) hz ();
  pipeline_hazard_controller #(.CNT_W(CNT_W), .REG_AW(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.rs_ID = '0; hz.rt_ID = '0; hz.use_rs_ID = 0; hz.use_rt_ID = 0;
    hz.dest_EX = '0; hz.dest_MEM = '0; hz.RegWrite_EX = 0; hz.RegWrite_MEM = 0; hz.d_readM_EX = 0;
    hz.mispredict_EX = 0; hz.i_mem_ready = 1; hz.d_mem_req = 0; hz.d_mem_ready = 1; hz.is_halted_WB = 0;
  endtask

  // Queue what this cycle must show, then advance the bench's own counter/halt model past the edge.
  task automatic step(input string tag, input logic [5:0] ctl);
    sb.push_back({ctl, exp_halted, exp_cnt});
    tq.push_back(tag);
    @(posedge clk);
    #1;
    if (!reset_n) begin
      exp_cnt = '0;
      exp_halted = 1'b0;
    end else begin
      if (hz.is_halted_WB) exp_halted = 1'b1;
      if (!ctl[5] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      check({t, "_ctl"}, {26'd0, hz.pc_write, hz.stall_IF_ID, hz.stall_ID_EX, hz.stall_EX_MEM,
                          hz.flush_IF_ID, hz.flush_ID_EX}, {26'd0, e.ctl});
      check({t, "_halted"}, {31'd0, hz.halted}, {31'd0, e.halted});
      check({t, "_cnt"}, {28'd0, hz.stall_cycles}, {28'd0, e.cnt});
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step("rst", RSTV);
    reset_n = 1'b1;
    step("norm", NORM);
    hz.d_readM_EX = 1; hz.RegWrite_EX = 1; hz.dest_EX = 2'd1; hz.rs_ID = 2'd1; hz.use_rs_ID = 1;
    step("load_use", HAZ);
    idle();
    step("after_lu", NORM);
    hz.RegWrite_MEM = 1; hz.dest_MEM = 2'd2; hz.rt_ID = 2'd2; hz.use_rt_ID = 1;
    step("mem_raw", ALU_HAZ);
    hz.use_rt_ID = 0;
    step("mem_nouse", NORM);
    idle();
    hz.RegWrite_EX = 1; hz.dest_EX = 2'd3; hz.rs_ID = 2'd3; hz.use_rs_ID = 1;
    step("ex_alu_raw", ALU_HAZ);
    hz.d_readM_EX = 1; hz.dest_EX = 2'd0; hz.rs_ID = 2'd0;
    step("reg0_lu", HAZ);
    hz.RegWrite_EX = 0;
    step("no_wr", NORM);
    hz.RegWrite_EX = 1; hz.mispredict_EX = 1;
    step("misp_lu", MISP);
    idle();
    hz.d_mem_req = 1; hz.d_mem_ready = 0; hz.mispredict_EX = 1;
    step("dmem1", ALL);
    step("dmem2", ALL);
    step("dmem3", ALL);
    hz.d_mem_ready = 1;
    step("dmem_done_misp", MISP);
    idle();
    step("dmem_after", NORM);
    hz.i_mem_ready = 0;
    step("imem1", IMW);
    hz.mispredict_EX = 1;
    step("imem_misp", RSTV);
    hz.mispredict_EX = 0;
    step("imem2", IMW);
    hz.i_mem_ready = 1;
    step("imem_redir", 6'b100010);
    step("imem_after", NORM);
    hz.i_mem_ready = 0;
    for (int i = 0; i < 8; i++) step("imem_sat", IMW);
    check("cnt_sat", {28'd0, hz.stall_cycles}, 32'hF);
    hz.i_mem_ready = 1;
    step("imem_clean", NORM);
    hz.is_halted_WB = 1;
    step("halt", ALL);
    hz.is_halted_WB = 0; hz.mispredict_EX = 1;
    step("halt_hold", ALL);
    idle();
    step("halt_idle", ALL);
    reset_n = 1'b0;
    step("rst2", RSTV);
    reset_n = 1'b1;
    step("post_rst", NORM);
    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
